// File: rtl/positron_argmax_sink_pkg.sv
// Shared types and helpers for the positron argmax sink.
package positron_argmax_sink_pkg;

  // Widest posit the signed compare helper handles.
  localparam int unsigned PositMaxW = 32;

  typedef enum logic {
    StCollect,
    StEmit
  } state_e;

  // Posits order like two's-complement integers; NaR is the most negative code.
  function automatic logic posit_gt(input logic signed [PositMaxW-1:0] a,
                                    input logic signed [PositMaxW-1:0] b);
    return a > b;
  endfunction

  // NaR bit pattern (1 followed by zeros) for a posit of the given width.
  function automatic logic [PositMaxW-1:0] posit_nar(input int unsigned width);
    return PositMaxW'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/positron_argmax_sink_posit_max_tracker.sv
// Running maximum / argmax of one frame of posit scores, plus the beat counter.
// max_o/idx_o already include the beat presented this cycle, so the caller can
// latch the final result on the closing beat itself.
module posit_max_tracker
  import positron_argmax_sink_pkg::*;
#(
  parameter int unsigned POSIT_WIDTH = 4,
  parameter int unsigned IDX_WIDTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_first_i,
  input  logic                   en_i,
  input  logic                   clr_i,
  input  logic [POSIT_WIDTH-1:0] posit_i,
  input  logic [IDX_WIDTH-1:0]   idx_i,
  output logic [POSIT_WIDTH-1:0] max_o,
  output logic [IDX_WIDTH-1:0]   idx_o,
  output logic [IDX_WIDTH-1:0]   cnt_o
);

  logic [POSIT_WIDTH-1:0] max_q, max_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;
  logic [IDX_WIDTH-1:0]   cnt_q, cnt_d;

  logic signed [PositMaxW-1:0] cand_sx, max_sx;

  assign cand_sx = PositMaxW'($signed(posit_i));
  assign max_sx  = PositMaxW'($signed(max_q));

  // Next max/idx: first beat loads, later beats replace only on strict greater.
  always_comb begin
    max_d = max_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    if (en_i) begin
      if (load_first_i || posit_gt(cand_sx, max_sx)) begin
        max_d = posit_i;
        idx_d = idx_i;
      end
      cnt_d = clr_i ? '0 : cnt_q + IDX_WIDTH'(1);
    end
  end

  // Tracker state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      max_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
    end else begin
      max_q <= max_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
    end
  end

  assign max_o = max_d;
  assign idx_o = idx_d;
  assign cnt_o = cnt_q;

endmodule

// File: rtl/positron_argmax_sink.sv
// Frame sink: argmax over each eow-delimited score frame, result sent as an
// AXI-stream beat {max_posit, class_idx} with a frame-length error in tuser.
module positron_argmax_sink
  import positron_argmax_sink_pkg::*;
#(
  parameter int unsigned POSIT_WIDTH = 4,
  parameter int unsigned POSIT_ES    = 0,
  parameter int unsigned NB_CLASSES  = 10,
  parameter int unsigned NB_IMAGES   = 2,
  parameter int unsigned IDX_WIDTH   = $clog2(NB_CLASSES)
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic                             rtr_o,
  input  logic                             rts_i,
  input  logic                             eow_i,
  input  logic [POSIT_WIDTH-1:0]           posit_i,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic [POSIT_WIDTH+IDX_WIDTH-1:0] m_axis_tdata,
  output logic                             m_axis_tuser,
  output logic                             m_axis_tlast
);

  localparam int unsigned ImgW = (NB_IMAGES > 1) ? $clog2(NB_IMAGES) : 1;
  localparam int unsigned DW   = POSIT_WIDTH + IDX_WIDTH;

  // ES does not affect ordering; only sanity-checked here.
  if (NB_CLASSES < 2 || POSIT_ES >= POSIT_WIDTH || POSIT_WIDTH > PositMaxW) begin : g_param_err
    $error("positron_argmax_sink: unsupported parameter combination");
  end

  state_e            state_q, state_d;
  logic [ImgW-1:0]   img_q, img_d;
  logic              rtr_q, tvalid_q;
  logic [DW-1:0]     tdata_q, tdata_d;
  logic              tuser_q, tuser_d;
  logic              tlast_q, tlast_d;

  logic                   accept, last_beat, close;
  logic [POSIT_WIDTH-1:0] trk_max;
  logic [IDX_WIDTH-1:0]   trk_idx, trk_cnt;

  assign accept    = rts_i && rtr_q;
  assign last_beat = (trk_cnt == IDX_WIDTH'(NB_CLASSES - 1));
  assign close     = accept && (eow_i || last_beat);

  posit_max_tracker #(
    .POSIT_WIDTH(POSIT_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_tracker (
    .clk         (clk),
    .rst         (rst),
    .load_first_i(trk_cnt == '0),
    .en_i        (accept),
    .clr_i       (close),
    .posit_i     (posit_i),
    .idx_i       (trk_cnt),
    .max_o       (trk_max),
    .idx_o       (trk_idx),
    .cnt_o       (trk_cnt)
  );

  // Next state, result latch on frame close, image counter on handshake.
  always_comb begin
    state_d = state_q;
    img_d   = img_q;
    tdata_d = tdata_q;
    tuser_d = tuser_q;
    tlast_d = tlast_q;
    unique case (state_q)
      StCollect: begin
        if (close) begin
          state_d = StEmit;
          tdata_d = {trk_max, trk_idx};
          // Error when eow and the beat count disagree about the frame end.
          tuser_d = eow_i ^ last_beat;
          tlast_d = (img_q == ImgW'(NB_IMAGES - 1));
        end
      end
      StEmit: begin
        if (m_axis_tready) begin
          state_d = StCollect;
          img_d   = (img_q == ImgW'(NB_IMAGES - 1)) ? '0 : img_q + ImgW'(1);
        end
      end
      default: state_d = StCollect;
    endcase
  end

  // State and registered outputs; rtr/tvalid are decodes of the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StCollect;
      img_q    <= '0;
      rtr_q    <= 1'b0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tuser_q  <= 1'b0;
      tlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      img_q    <= img_d;
      rtr_q    <= (state_d == StCollect);
      tvalid_q <= (state_d == StEmit);
      tdata_q  <= tdata_d;
      tuser_q  <= tuser_d;
      tlast_q  <= tlast_d;
    end
  end

  assign rtr_o         = rtr_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_positron_argmax_sink.sv
// Scoreboard bench for positron_argmax_sink: frame-level argmax model feeds an
// expected-result queue, a monitor pops and compares on every AXI handshake.
module tb_positron_argmax_sink;

  localparam int PW = 4;
  localparam int NC = 10;
  localparam int NI = 2;
  localparam int IW = $clog2(NC);
  localparam int EW = PW + IW + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rtr_o;
  logic          rts_i = 1'b0;
  logic          eow_i = 1'b0;
  logic [PW-1:0] posit_i = '0;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic [PW+IW-1:0] m_axis_tdata;
  logic          m_axis_tuser;
  logic          m_axis_tlast;

  positron_argmax_sink #(
    .POSIT_WIDTH(PW),
    .POSIT_ES   (0),
    .NB_CLASSES (NC),
    .NB_IMAGES  (NI),
    .IDX_WIDTH  (IW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rtr_o        (rtr_o),
    .rts_i        (rts_i),
    .eow_i        (eow_i),
    .posit_i      (posit_i),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tuser (m_axis_tuser),
    .m_axis_tlast (m_axis_tlast)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [EW-1:0] sb[$];
  int            img_m = 0;
  int            tr_mode = 0;   // 0: ready, 1: random, 2: held low

  logic [PW-1:0] frame_p[NC];
  int            frame_len;
  bit            frame_eow;

  // Downstream ready, changed just after each rising edge.
  always @(posedge clk) begin
    #1;
    case (tr_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = 1'($urandom_range(0, 1));
      default: m_axis_tready = 1'b0;
    endcase
  end

  // Monitor: stall stability and scoreboard compare at each handshake.
  bit            stall_prev = 0;
  logic [EW-1:0] hold_v;
  always @(negedge clk) begin
    logic [EW-1:0] got, exp_v;
    got = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
    if (rst) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        n_cmp++;
        if (!m_axis_tvalid || got !== hold_v) begin
          n_err++;
          $display("FAIL stall_stable: got valid=%0b v=%h, required valid=1 v=%h",
                   m_axis_tvalid, got, hold_v);
        end
      end
      if (m_axis_tvalid) begin
        n_cmp++;
        if (rtr_o) begin
          n_err++;
          $display("FAIL rtr_in_emit: got rtr_o=1, required 0 while tvalid=1");
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_result: got tdata=%h tuser=%0b tlast=%0b, required none",
                   m_axis_tdata, m_axis_tuser, m_axis_tlast);
        end else begin
          exp_v = sb.pop_front();
          if (got !== exp_v) begin
            n_err++;
            $display("FAIL result: got tdata=%h tuser=%0b tlast=%0b, required tdata=%h tuser=%0b tlast=%0b",
                     m_axis_tdata, m_axis_tuser, m_axis_tlast,
                     exp_v[EW-1:2], exp_v[1], exp_v[0]);
          end
        end
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      hold_v     = got;
    end
  end

  // Reference model: argmax over the frame, lowest index on ties.
  task automatic model_push();
    int   best;
    logic user;
    best = 0;
    for (int i = 1; i < frame_len; i++)
      if ($signed(frame_p[i]) > $signed(frame_p[best])) best = i;
    user = frame_eow != (frame_len == NC);
    sb.push_back({frame_p[best], IW'(best), user, 1'(img_m == NI - 1)});
    img_m = (img_m + 1) % NI;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic send_beat(input logic [PW-1:0] p, input logic e, input bit gaps);
    int guard;
    guard = 0;
    if (gaps) begin
      while ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        rts_i   = 1'b0;
        posit_i = PW'($urandom);
        eow_i   = 1'($urandom);
      end
    end
    @(negedge clk);
    rts_i   = 1'b1;
    posit_i = p;
    eow_i   = e;
    while (!rtr_o && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      n_cmp++;
      n_err++;
      $display("FAIL rtr_timeout: got rtr_o=0 for 200 cycles, required 1");
    end
    @(posedge clk);
  endtask

  task automatic run_frame(input bit gaps, input bit push);
    if (push) model_push();
    for (int i = 0; i < frame_len; i++)
      send_beat(frame_p[i], 1'(frame_eow && i == frame_len - 1), gaps);
    @(negedge clk);
    rts_i = 1'b0;
    eow_i = 1'b0;
    if (push) check("latency_tvalid_rtr", {m_axis_tvalid, rtr_o}, 2'b10);
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((sb.size() != 0 || m_axis_tvalid) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("drain", sb.size(), 0);
  endtask

  task automatic fill_const(input logic [PW-1:0] v);
    for (int i = 0; i < NC; i++) frame_p[i] = v;
    frame_len = NC;
    frame_eow = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values.
    repeat (3) @(negedge clk);
    check("reset_outputs", {rtr_o, m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast}, '0);
    rst = 1'b0;
    @(negedge clk);
    check("rtr_after_reset", rtr_o, 1);

    // Ascending scores with a peak at index 5.
    frame_p = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd6, 4'd0, 4'd0, 4'd0};
    frame_len = NC; frame_eow = 1;
    run_frame(0, 1);
    // Ties, NaR, negative values.
    fill_const(4'b0100); run_frame(0, 1);
    fill_const(4'b1000); run_frame(0, 1);
    fill_const(4'b1111); frame_p[3] = 4'b0011; run_frame(0, 1);
    wait_drain();

    // Back-pressure: first result held for 5 cycles.
    tr_mode = 2;
    frame_p = '{4'd3, 4'd1, 4'd6, 4'd2, 4'd6, 4'd0, 4'd1, 4'd5, 4'd4, 4'd2};
    frame_len = NC; frame_eow = 1;
    run_frame(0, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_rtr_tvalid", {rtr_o, m_axis_tvalid}, 2'b01);
    end
    tr_mode = 0;
    fill_const(4'b1101); frame_p[8] = 4'b0001; run_frame(0, 1);
    wait_drain();

    // Short frame (eow on beat 4) and long frame without eow.
    for (int i = 0; i < NC; i++) frame_p[i] = PW'(i + 9);
    frame_len = 5; frame_eow = 1; run_frame(0, 1);
    frame_len = NC; frame_eow = 0; run_frame(0, 1);
    wait_drain();

    // Random frames with input gaps and random downstream ready.
    tr_mode = 1;
    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < NC; i++) frame_p[i] = PW'($urandom);
      frame_len = $urandom_range(1, NC);
      frame_eow = (frame_len < NC) ? 1'b1 : 1'($urandom_range(0, 1));
      run_frame(1, 1);
    end
    tr_mode = 0;
    wait_drain();

    // Leave the image counter at 1 so a reset must clear it.
    if (img_m == 0) begin
      fill_const(4'b0010); frame_p[6] = 4'b0110; run_frame(0, 1);
      wait_drain();
    end

    // Reset mid-frame after beat 6.
    for (int i = 0; i < NC; i++) frame_p[i] = PW'(7 - i);
    frame_len = 7; frame_eow = 0;
    run_frame(0, 0);
    rst = 1'b1;
    @(negedge clk);
    check("midframe_reset_outputs", {rtr_o, m_axis_tvalid, m_axis_tdata}, '0);
    rst = 1'b0;
    img_m = 0;
    @(negedge clk);
    check("midframe_reset_rtr", rtr_o, 1);
    frame_p = '{4'd0, 4'd2, 4'd1, 4'd6, 4'd3, 4'd2, 4'd1, 4'd0, 4'd6, 4'd4};
    frame_len = NC; frame_eow = 1;
    run_frame(0, 1);
    wait_drain();

    // Reset while a result is pending in EMIT.
    tr_mode = 2;
    fill_const(4'b0101); frame_p[2] = 4'b0111; run_frame(0, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("emit_reset_tvalid", m_axis_tvalid, 0);
    rst = 1'b0;
    sb.delete();
    img_m = 0;
    tr_mode = 0;
    fill_const(4'b0001); frame_p[9] = 4'b0011; run_frame(0, 1);
    wait_drain();
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
